// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width, hazard FSM encoding and
// the load-use hazard compare.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 6;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    // Load in execute whose destination feeds a source of the decode instruction.
    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic lu_hazard(
        input logic [REG_IDX_W-1:0] src_1,
        input logic [REG_IDX_W-1:0] src_2,
        input logic                 uses_src_2,
        input logic [REG_IDX_W-1:0] dst,
        input logic                 mem_read,
        input logic                 reg_write
    );
        return mem_read & reg_write & (dst != '0)
            & ((dst == src_1) | (uses_src_2 & (dst == src_2)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Decode/execute hazard signals and the pipeline-register controls fed back.
// slave: the hazard unit; master: the pipeline that supplies operands and obeys.
interface hazard_control_unit_if;
    import pipeline_pkg::*;

    logic [REG_IDX_W-1:0] d_src_reg_1;
    logic [REG_IDX_W-1:0] d_src_reg_2;
    logic                 d_uses_src_2;
    logic [REG_IDX_W-1:0] x_dst_reg;
    logic                 x_mem_read;
    logic                 x_reg_write;
    logic                 x_redirect;
    logic                 m_mem_busy;
    logic                 f_stall;
    logic                 d_stall;
    logic                 x_bubble;
    logic                 d_flush;
    logic                 xm_stall;

    modport master (
        output d_src_reg_1, d_src_reg_2, d_uses_src_2, x_dst_reg,
        output x_mem_read, x_reg_write, x_redirect, m_mem_busy,
        input  f_stall, d_stall, x_bubble, d_flush, xm_stall
    );

    modport slave (
        input  d_src_reg_1, d_src_reg_2, d_uses_src_2, x_dst_reg,
        input  x_mem_read, x_reg_write, x_redirect, m_mem_busy,
        output f_stall, d_stall, x_bubble, d_flush, xm_stall
    );

endinterface

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with enable and async active-low clear.
module event_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    // Count one per enabled cycle, wrapping naturally.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control: load-use bubbles, execute redirects and data-memory wait
// states, with stall/flush performance counters. Priority: mem busy > redirect > load-use.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES = 1,  // 1..7
    parameter int unsigned CNT_W           = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_control_unit_if.slave hz,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int unsigned CntW = 3;

    hz_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              lu_hit;
    logic              f_stall_c, d_stall_c, x_bubble_c, d_flush_c, xm_stall_c;

    assign lu_hit = lu_hazard(hz.d_src_reg_1, hz.d_src_reg_2, hz.d_uses_src_2,
                              hz.x_dst_reg, hz.x_mem_read, hz.x_reg_write);

    // Next-state and Mealy control outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f_stall_c  = 1'b0;
        d_stall_c  = 1'b0;
        x_bubble_c = 1'b0;
        d_flush_c  = 1'b0;
        xm_stall_c = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                if (hz.m_mem_busy) begin
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    xm_stall_c = 1'b1;
                    state_d    = HZ_MEM_WAIT;
                end else if (hz.x_redirect) begin
                    // Redirect squashes the dependent instruction, so no bubble is owed.
                    d_flush_c  = 1'b1;
                    x_bubble_c = 1'b1;
                end else if (lu_hit) begin
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    x_bubble_c = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        cnt_d   = CntW'(LOAD_USE_CYCLES - 1);
                        state_d = HZ_LU_STALL;
                    end
                end
            end
            HZ_LU_STALL: begin
                if (hz.m_mem_busy) begin
                    // Remaining bubble count is kept in cnt_q across the wait.
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    xm_stall_c = 1'b1;
                    state_d    = HZ_MEM_WAIT;
                end else if (hz.x_redirect) begin
                    d_flush_c  = 1'b1;
                    x_bubble_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = HZ_RUN;
                end else begin
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    x_bubble_c = 1'b1;
                    cnt_d      = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = HZ_RUN;
                    end
                end
            end
            HZ_MEM_WAIT: begin
                if (hz.m_mem_busy) begin
                    // Execute is frozen, so a redirect here is not acted upon.
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    xm_stall_c = 1'b1;
                end else if (hz.x_redirect) begin
                    d_flush_c  = 1'b1;
                    x_bubble_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = HZ_RUN;
                end else begin
                    // Release cycle: no stall, resume any interrupted load-use stall.
                    state_d = (cnt_q != '0) ? HZ_LU_STALL : HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and pending-bubble count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs do.
    assign hz.f_stall  = reset & f_stall_c;
    assign hz.d_stall  = reset & d_stall_c;
    assign hz.x_bubble = reset & x_bubble_c;
    assign hz.d_flush  = reset & d_flush_c;
    assign hz.xm_stall = reset & xm_stall_c;

    event_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .en_i    (hz.f_stall),
        .count_o (stall_count)
    );

    event_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .en_i    (hz.d_flush),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: single-cycle vector table on a LOAD_USE_CYCLES=1 unit with
// 3-bit counters, plus multi-cycle sequences on a LOAD_USE_CYCLES=3 unit.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [5:0] s1;
        logic [5:0] s2;
        logic       u2;
        logic [5:0] xd;
        logic       mr;
        logic       rw;
        logic       rd;
        logic       bz;
    } hz_in_t;

    typedef struct {
        hz_in_t     in;
        logic [4:0] exp;  // {f_stall, d_stall, x_bubble, d_flush, xm_stall}
        string      name;
    } vec_t;

    logic        clock;
    logic        reset;
    hz_in_t      in1, in3;
    logic [4:0]  out1, out3;
    logic [2:0]  sc1, fc1;
    logic [31:0] sc3, fc3;
    int          checks;
    int          errors;
    vec_t        vecs[11];

    hazard_control_unit_if if1 ();
    hazard_control_unit_if if3 ();

    assign if1.d_src_reg_1 = in1.s1;
    assign if1.d_src_reg_2 = in1.s2;
    assign if1.d_uses_src_2 = in1.u2;
    assign if1.x_dst_reg   = in1.xd;
    assign if1.x_mem_read  = in1.mr;
    assign if1.x_reg_write = in1.rw;
    assign if1.x_redirect  = in1.rd;
    assign if1.m_mem_busy  = in1.bz;
    assign out1 = {if1.f_stall, if1.d_stall, if1.x_bubble, if1.d_flush, if1.xm_stall};

    assign if3.d_src_reg_1 = in3.s1;
    assign if3.d_src_reg_2 = in3.s2;
    assign if3.d_uses_src_2 = in3.u2;
    assign if3.x_dst_reg   = in3.xd;
    assign if3.x_mem_read  = in3.mr;
    assign if3.x_reg_write = in3.rw;
    assign if3.x_redirect  = in3.rd;
    assign if3.m_mem_busy  = in3.bz;
    assign out3 = {if3.f_stall, if3.d_stall, if3.x_bubble, if3.d_flush, if3.xm_stall};

    hazard_control_unit #(
        .LOAD_USE_CYCLES (1),
        .CNT_W           (3)
    ) u_dut1 (
        .clock       (clock),
        .reset       (reset),
        .hz          (if1),
        .stall_count (sc1),
        .flush_count (fc1)
    );

    hazard_control_unit #(
        .LOAD_USE_CYCLES (3),
        .CNT_W           (32)
    ) u_dut3 (
        .clock       (clock),
        .reset       (reset),
        .hz          (if3),
        .stall_count (sc3),
        .flush_count (fc3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic hz_in_t mk_in(input logic [5:0] s1, input logic [5:0] s2,
                                     input logic u2, input logic [5:0] xd,
                                     input logic mr, input logic rw,
                                     input logic rd, input logic bz);
        hz_in_t r;
        r.s1 = s1; r.s2 = s2; r.u2 = u2; r.xd = xd;
        r.mr = mr; r.rw = rw; r.rd = rd; r.bz = bz;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step1(input hz_in_t i, input logic [4:0] e, input string name);
        @(negedge clock);
        in1 = i;
        #1;
        check(name, {27'd0, out1}, {27'd0, e});
    endtask

    task automatic step3(input hz_in_t i, input logic [4:0] e, input string name);
        @(negedge clock);
        in3 = i;
        #1;
        check(name, {27'd0, out3}, {27'd0, e});
    endtask

    task automatic set_vec(input int idx, input hz_in_t i, input logic [4:0] e,
                           input string name);
        vecs[idx].in   = i;
        vecs[idx].exp  = e;
        vecs[idx].name = name;
    endtask

    hz_in_t hit;
    hz_in_t idle;

    initial begin
        checks = 0;
        errors = 0;
        idle   = '0;
        hit    = mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0);

        set_vec(0,  mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0), 5'b11100, "lu src1");
        set_vec(1,  mk_in(6'd0, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0), 5'b00000, "lu r0");
        set_vec(2,  mk_in(6'd1, 6'd7, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0), 5'b00000, "src2 unused");
        set_vec(3,  mk_in(6'd1, 6'd7, 1'b1, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0), 5'b11100, "lu src2");
        set_vec(4,  mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0), 5'b00000, "not load");
        set_vec(5,  mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0), 5'b00000, "no wb");
        set_vec(6,  mk_in(6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), 5'b00110, "redirect");
        set_vec(7,  mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0), 5'b00110, "redir kills lu");
        set_vec(8,  mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1), 5'b11001, "busy wins");
        set_vec(9,  mk_in(6'd5, 6'd6, 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b0), 5'b00000, "no match");
        set_vec(10, mk_in(6'd63, 6'd0, 1'b0, 6'd63, 1'b1, 1'b1, 1'b0, 1'b0), 5'b11100, "lu r63");

        // Reset with busy asserted: controls must still read zero.
        reset = 1'b0;
        in1   = mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        in3   = '0;
        #1;
        check("reset ctrl1", {27'd0, out1}, 32'd0);
        check("reset ctrl3", {27'd0, out3}, 32'd0);
        check("reset sc1", {29'd0, sc1}, 32'd0);
        check("reset fc3", fc3, 32'd0);
        repeat (2) @(negedge clock);
        in1   = '0;
        reset = 1'b1;

        // Single-cycle table, each vector followed by an idle cycle.
        for (int i = 0; i < 11; i++) begin
            step1(vecs[i].in, vecs[i].exp, vecs[i].name);
            step1(idle, 5'b00000, "idle after vec");
        end
        check("table stall_count", {29'd0, sc1}, 32'd4);
        check("table flush_count", {29'd0, fc1}, 32'd2);

        // 3-bit counter wraps: 4 + 5 = 9 -> 1.
        for (int i = 0; i < 5; i++) step1(hit, 5'b11100, "wrap lu");
        step1(idle, 5'b00000, "wrap idle");
        check("stall wrap", {29'd0, sc1}, 32'd1);

        // Three bubbles then RUN.
        step3(hit, 5'b11100, "lu3 b1");
        step3(hit, 5'b11100, "lu3 b2");
        step3(hit, 5'b11100, "lu3 b3");
        step3(idle, 5'b00000, "lu3 done");
        check("lu3 stall_count", sc3, 32'd3);

        // Redirect on the second bubble drops the third.
        step3(hit, 5'b11100, "redir b1");
        step3(mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0), 5'b00110, "redir b2");
        step3(idle, 5'b00000, "redir no b3");
        check("redir flush_count", fc3, 32'd1);
        check("redir stall_count", sc3, 32'd4);

        // Memory busy for 4 cycles during a load-use hit.
        for (int i = 0; i < 4; i++)
            step3(mk_in(6'd5, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1), 5'b11001, "busy lu");
        step3(hit, 5'b00000, "busy release");
        step3(hit, 5'b11100, "post busy b1");
        step3(hit, 5'b11100, "post busy b2");
        step3(hit, 5'b11100, "post busy b3");
        step3(idle, 5'b00000, "post busy done");
        check("busy stall_count", sc3, 32'd11);

        // Busy in the middle of a load-use stall freezes the bubble count.
        step3(hit, 5'b11100, "freeze b1");
        step3(mk_in(6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1), 5'b11001, "freeze busy1");
        step3(mk_in(6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1), 5'b11001, "busy ign redir");
        step3(idle, 5'b00000, "freeze release");
        step3(idle, 5'b11100, "freeze b2");
        step3(idle, 5'b11100, "freeze b3");
        step3(idle, 5'b00000, "freeze done");
        check("freeze stall_count", sc3, 32'd16);
        check("freeze flush_count", fc3, 32'd1);

        // Reset asserted in the middle of MEM_WAIT.
        step3(mk_in(6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1), 5'b11001, "mw enter");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid reset ctrl", {27'd0, out3}, 32'd0);
        check("mid reset sc3", sc3, 32'd0);
        check("mid reset fc3", fc3, 32'd0);
        check("mid reset sc1", {29'd0, sc1}, 32'd0);
        @(negedge clock);
        in3   = '0;
        reset = 1'b1;
        step3(hit, 5'b11100, "run after reset");
        step3(idle, 5'b11100, "after reset b2");
        step3(idle, 5'b11100, "after reset b3");
        step3(idle, 5'b00000, "after reset done");
        check("after reset sc3", sc3, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
